// File: rtl/diff_rx_deser.sv
// Multi-lane serial-to-parallel deserializer with sync-word hunt on lane 0.
// Alignment goes through a confirm/lock/unlock sequence; bypass gives an unaligned free-running split.
`timescale 1ns/1ps

// state      | meaning
// ST_HUNT    | bit-by-bit search for SYNC_WORD on lane 0, no outputs
// ST_CONFIRM | aligned, counting consecutive good sync slots before lock
// ST_LOCKED  | aligned and emitting words, tracking sync misses
// ST_FREE    | bypass, word split every WORD_W cycles with no alignment
module diff_rx_deser #(
  parameter int                LANES      = 2,
  parameter int                WORD_W     = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD  = 8'hA5,
  parameter int                FRAME_LEN  = 4,
  parameter int                LOCK_CNT   = 2,
  parameter int                UNLOCK_CNT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      align_en,
  input  logic [LANES-1:0]          data_in,
  output logic [LANES*WORD_W-1:0]   word_out,
  output logic                      word_valid,
  output logic                      frame_start,
  output logic                      locked,
  output logic [7:0]                sync_err
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
  localparam logic [HW-1:0] HITS_LAST = HW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_CONFIRM, ST_LOCKED, ST_FREE} state_t;

  state_t                         state;
  logic [LANES-1:0][WORD_W-1:0]   sr;
  logic [LANES-1:0][WORD_W-1:0]   cand;
  logic [BW-1:0]                  bit_cnt;
  logic [IW-1:0]                  word_idx;
  logic [HW-1:0]                  hits;
  logic [MW-1:0]                  miss;
  logic                           boundary;
  logic                           sync_slot;
  logic                           sync_hit;

  // Candidate word includes the bit being sampled on this edge.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cand[i] = {sr[i][WORD_W-2:0], data_in[i]};
    end
  end

  assign boundary  = (bit_cnt == BIT_LAST);
  assign sync_slot = boundary && (word_idx == '0);
  assign sync_hit  = (cand[0] == SYNC_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HUNT;
      sr          <= '0;
      bit_cnt     <= '0;
      word_idx    <= '0;
      hits        <= '0;
      miss        <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= '0;
    end else begin
      sr          <= cand;
      word_valid  <= 1'b0;
      frame_start <= 1'b0;

      // Default counter advance; individual states override below.
      if (boundary) begin
        bit_cnt  <= '0;
        word_idx <= (word_idx == IDX_LAST) ? '0 : word_idx + 1'b1;
      end else begin
        bit_cnt  <= bit_cnt + 1'b1;
      end

      if (!align_en) begin
        if (state != ST_FREE) begin
          state    <= ST_FREE;
          bit_cnt  <= '0;
          word_idx <= '0;
          locked   <= 1'b0;
        end else if (boundary) begin
          word_out    <= cand;
          word_valid  <= 1'b1;
          frame_start <= (word_idx == '0);
        end
      end else begin
        case (state)
          ST_FREE: begin
            state <= ST_HUNT;
            hits  <= '0;
            miss  <= '0;
          end

          ST_HUNT: begin
            if (sync_hit) begin
              bit_cnt  <= '0;
              word_idx <= IW'(1);
              hits     <= HW'(1);
              if (LOCK_CNT == 1) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
                miss   <= '0;
              end else begin
                state  <= ST_CONFIRM;
              end
            end
          end

          ST_CONFIRM: begin
            if (sync_slot) begin
              if (sync_hit) begin
                hits <= hits + 1'b1;
                if (hits == HITS_LAST) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                  miss   <= '0;
                end
              end else begin
                state <= ST_HUNT;
              end
            end
          end

          ST_LOCKED: begin
            if (boundary) begin
              word_out    <= cand;
              word_valid  <= 1'b1;
              frame_start <= (word_idx == '0);
            end
            if (sync_slot) begin
              if (sync_hit) begin
                miss <= '0;
              end else begin
                miss <= miss + 1'b1;
                if (sync_err != 8'hFF) sync_err <= sync_err + 8'd1;
                if (miss == MISS_LAST) begin
                  state  <= ST_HUNT;
                  locked <= 1'b0;
                end
              end
            end
          end

          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diff_rx_deser.sv
// Randomized bench for diff_rx_deser against a frame-position reference model.
`timescale 1ns/1ps

module tb_diff_rx_deser;

  localparam int        LANES = 2;
  localparam int        W     = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int        FL    = 4;
  localparam int        LCNT  = 2;
  localparam int        UCNT  = 2;
  localparam int        FBITS = W * FL;

  localparam int M_HUNT = 0, M_CONFIRM = 1, M_LOCKED = 2, M_FREE = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 align_en = 1'b1;
  logic [LANES-1:0]     data_in = '0;
  logic [LANES*W-1:0]   word_out;
  logic                 word_valid;
  logic                 frame_start;
  logic                 locked;
  logic [7:0]           sync_err;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: position counted in bits from the start of the frame
  logic [W-1:0]        m_sr [LANES];
  int                  m_mode, m_pos, m_good, m_bad, m_err;
  logic                m_valid, m_fs, m_locked;
  logic [LANES*W-1:0]  m_word;

  diff_rx_deser #(
    .LANES(LANES), .WORD_W(W), .SYNC_WORD(SYNC),
    .FRAME_LEN(FL), .LOCK_CNT(LCNT), .UNLOCK_CNT(UCNT)
  ) dut (
    .clk(clk), .rst(rst), .align_en(align_en), .data_in(data_in),
    .word_out(word_out), .word_valid(word_valid), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_sr[i] = '0;
    m_mode = M_HUNT; m_pos = 0; m_good = 0; m_bad = 0; m_err = 0;
    m_valid = 0; m_fs = 0; m_locked = 0; m_word = '0;
  endtask

  task automatic model_step(input logic al, input logic [LANES-1:0] bits);
    logic [W-1:0] c [LANES];
    int  slot;
    bit  bnd, hit;
    for (int i = 0; i < LANES; i++) c[i] = {m_sr[i][W-2:0], bits[i]};
    bnd  = (m_pos % W) == W - 1;
    slot = m_pos / W;
    hit  = (c[0] == SYNC);
    m_valid = 0;
    m_fs    = 0;
    if (!al) begin
      if (m_mode != M_FREE) begin
        m_mode = M_FREE; m_pos = 0; m_locked = 0;
      end else begin
        if (bnd) begin
          m_valid = 1; m_fs = (slot == 0); m_word = {c[1], c[0]};
        end
        m_pos = (m_pos + 1) % FBITS;
      end
    end else if (m_mode == M_FREE) begin
      m_mode = M_HUNT; m_good = 0; m_bad = 0;
    end else if (m_mode == M_HUNT) begin
      if (hit) begin
        m_pos  = W;
        m_good = 1;
        if (LCNT == 1) begin m_mode = M_LOCKED; m_locked = 1; m_bad = 0; end
        else m_mode = M_CONFIRM;
      end
    end else if (m_mode == M_CONFIRM) begin
      if (bnd && slot == 0) begin
        if (hit) begin
          m_good++;
          if (m_good == LCNT) begin m_mode = M_LOCKED; m_locked = 1; m_bad = 0; end
        end else m_mode = M_HUNT;
      end
      m_pos = (m_pos + 1) % FBITS;
    end else begin
      if (bnd) begin
        m_valid = 1; m_fs = (slot == 0); m_word = {c[1], c[0]};
      end
      if (bnd && slot == 0) begin
        if (hit) m_bad = 0;
        else begin
          m_bad++;
          if (m_err < 255) m_err++;
          if (m_bad == UCNT) begin m_mode = M_HUNT; m_locked = 0; end
        end
      end
      m_pos = (m_pos + 1) % FBITS;
    end
    for (int i = 0; i < LANES; i++) m_sr[i] = c[i];
  endtask

  task automatic step(input logic al, input logic [LANES-1:0] bits);
    align_en = al;
    data_in  = bits;
    @(posedge clk);
    model_step(al, bits);
    #1;
    check("word_valid", word_valid, m_valid);
    check("locked", locked, m_locked);
    check("sync_err", sync_err, m_err);
    check("frame_start", frame_start, m_valid ? m_fs : 1'b0);
    if (m_valid) check("word_out", word_out, m_word);
  endtask

  task automatic send_word(input logic al, input logic [7:0] w0, input logic [7:0] w1);
    for (int b = W - 1; b >= 0; b--) step(al, {w1[b], w0[b]});
  endtask

  task automatic send_frame(input logic [7:0] s0, input bit zero_fill);
    logic [7:0] f;
    send_word(1'b1, s0, 8'($urandom));
    for (int k = 1; k < FL; k++) begin
      f = zero_fill ? 8'h00 : 8'($urandom);
      send_word(1'b1, f, 8'($urandom));
    end
  endtask

  task automatic do_reset(input logic al);
    align_en = al;
    data_in  = '0;
    rst      = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_out", word_out, 0);
    check("rst_valid", word_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] bad_sync();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SYNC) b = b ^ 8'h01;
    return b;
  endfunction

  initial begin
    logic [7:0] seq0 [8];
    logic [7:0] rb;
    seq0 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h55, 8'h66};

    // T1: lock on second sync boundary
    do_reset(1'b1);
    for (int k = 0; k < 5; k++) send_word(1'b1, seq0[k], 8'(8'h80 + k));
    check("t1_locked", locked, 1);
    send_word(1'b1, seq0[5], 8'h85);
    check("t1_word", word_out, 16'h8544);
    check("t1_valid", word_valid, 1);
    send_word(1'b1, seq0[6], 8'h86);
    send_word(1'b1, seq0[7], 8'h87);
    send_word(1'b1, 8'hA5, 8'h88);
    check("t1_fs", frame_start, 1);

    // T2: bit offset, then a corrupted sync slot during confirm
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 2'($urandom));
    for (int k = 0; k < 4; k++) send_word(1'b1, seq0[k], 8'($urandom));
    send_word(1'b1, 8'h5A, 8'($urandom));
    check("t2_unlocked", locked, 0);
    for (int k = 1; k < 8; k++) send_word(1'b1, seq0[k], 8'($urandom));
    send_word(1'b1, 8'hA5, 8'($urandom));
    check("t2_relock", locked, 1);

    // T3: single miss keeps lock, double miss drops it
    do_reset(1'b1);
    send_frame(SYNC, 0);
    send_frame(SYNC, 0);
    check("t3_locked", locked, 1);
    send_frame(bad_sync(), 0);
    check("t3_one_miss_locked", locked, 1);
    check("t3_one_miss_err", sync_err, 1);
    send_frame(SYNC, 0);
    send_frame(bad_sync(), 0);
    rb = bad_sync();
    send_word(1'b1, rb, 8'($urandom));
    check("t3_unlock", locked, 0);
    check("t3_err", sync_err, 3);
    for (int k = 1; k < FL; k++) send_word(1'b1, 8'($urandom), 8'($urandom));

    // T4: bypass mode
    do_reset(1'b0);
    step(1'b0, 2'($urandom));
    for (int k = 0; k < 12; k++) begin
      send_word(1'b0, 8'hC3, 8'($urandom));
      check("t4_valid", word_valid, 1);
      check("t4_byte", word_out[7:0], 8'hC3);
      check("t4_fs", frame_start, (k % FL) == 0);
      check("t4_locked", locked, 0);
    end
    send_word(1'b1, 8'h00, 8'($urandom));

    // T5: async reset mid-word
    do_reset(1'b1);
    send_frame(SYNC, 0);
    send_frame(SYNC, 0);
    for (int b = W - 1; b >= W - 5; b--) step(1'b1, {1'($urandom), SYNC[b]});
    #2;
    rst = 1'b1;
    #1;
    check("t5_word_out", word_out, 0);
    check("t5_valid", word_valid, 0);
    check("t5_fs", frame_start, 0);
    check("t5_locked", locked, 0);
    check("t5_sync_err", sync_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(SYNC, 1);
    check("t5_not_yet", locked, 0);
    send_word(1'b1, SYNC, 8'($urandom));
    check("t5_relock", locked, 1);

    // T6: sync_err saturation across repeated unlock/relock
    do_reset(1'b1);
    for (int it = 0; it < 150; it++) begin
      send_frame(SYNC, 1);
      send_frame(SYNC, 1);
      send_frame(bad_sync(), 1);
      send_frame(bad_sync(), 1);
    end
    check("t6_sat", sync_err, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
